imem_loader: RTL

//   Write-side companion of the instruction memory: receives a byte stream (count header + big-endian

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_word_assembler.sv | 41 ++++
 rtl/imem_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, defaults and
// word-address arithmetic.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int unsigned DEFAULT_SIZE = 128;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  // Byte address of word k; wraps at 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] k);
    return base + {14'd0, k, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Shifts stream bytes in MSB-first and flags the byte that completes a 32-bit word.
module imem_loader_word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  // Only the three earlier bytes need storing; the fourth arrives with word_full.
  logic [23:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_next = {word_q, byte_in};
    word_full = shift_en && (cnt_q == 2'd3);
    if (clear) begin
      word_d = 24'd0;
      cnt_d  = 2'd0;
    end else if (shift_en) begin
      word_d = word_next[23:0];
      cnt_d  = cnt_q + 2'd1;
    end else begin
      word_d = word_q;
      cnt_d  = cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q <= 24'd0;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a counted big-endian word stream into instruction memory and holds the CPU
// until the load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned SIZE = DEFAULT_SIZE,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        overflow,
  output logic [15:0] word_count
);

  localparam logic [16:0] SIZE_W = 17'(SIZE);

  state_e      state_q, state_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [15:0] n_q, n_d, k_q, k_d, word_count_q, word_count_d;
  logic        byte_ready_q, byte_ready_d, wr_en_q, wr_en_d;
  logic        cpu_hold_q, cpu_hold_d, done_q, done_d, overflow_q, overflow_d;
  logic [31:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic        start_acc, xfer, shift_en, word_full;
  logic [31:0] word_next;
  logic [16:0] k_inc;

  assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign xfer      = byte_valid && byte_ready_q;
  assign shift_en  = xfer && (state_q == ST_LOAD);
  assign k_inc     = {1'b0, k_q} + 17'd1;

  imem_loader_word_assembler u_asm (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_acc),
    .shift_en  (shift_en),
    .byte_in   (byte_in),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // hdr_cnt==2 is a one-cycle header evaluation slot before LOAD or DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = start ? ST_HDR : state_q;
      ST_HDR:           state_d = (hdr_cnt_q != 2'd2) ? ST_HDR :
                                  ((n_q == 16'd0) ? ST_DONE : ST_LOAD);
      ST_LOAD:          state_d = word_full ? ST_COMMIT : ST_LOAD;
      ST_COMMIT:        state_d = (k_inc[15:0] == n_q) ? ST_DONE : ST_LOAD;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hdr_cnt_d    = hdr_cnt_q;
    n_d          = n_q;
    k_d          = k_q;
    overflow_d   = overflow_q;
    word_count_d = word_count_q;
    if (start_acc) begin
      hdr_cnt_d    = 2'd0;
      n_d          = 16'd0;
      k_d          = 16'd0;
      overflow_d   = 1'b0;
      word_count_d = 16'd0;
    end else begin
      if ((state_q == ST_HDR) && xfer) begin
        hdr_cnt_d = hdr_cnt_q + 2'd1;
        if (hdr_cnt_q == 2'd0) begin
          n_d = {byte_in, n_q[7:0]};
        end else begin
          n_d        = {n_q[15:8], byte_in};
          overflow_d = overflow_q || ({1'b0, n_q[15:8], byte_in} > SIZE_W);
        end
      end else begin
        hdr_cnt_d = hdr_cnt_q;
      end
      k_d = (state_q == ST_COMMIT) ? k_inc[15:0] : k_q;
      if (state_d == ST_COMMIT) begin
        word_count_d = (k_inc > SIZE_W) ? SIZE_W[15:0] : k_inc[15:0];
      end else begin
        word_count_d = word_count_q;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    byte_ready_d = (state_d == ST_LOAD) || ((state_d == ST_HDR) && (hdr_cnt_d != 2'd2));
    cpu_hold_d   = state_d inside {ST_HDR, ST_LOAD, ST_COMMIT};
    done_d       = (state_d == ST_DONE);
    wr_en_d      = (state_d == ST_COMMIT) && ({1'b0, k_q} < SIZE_W);
    if (wr_en_d) begin
      wr_addr_d = word_addr(BASE, k_q);
      wr_data_d = word_next;
    end else begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hdr_cnt_q    <= 2'd0;
      n_q          <= 16'd0;
      k_q          <= 16'd0;
      word_count_q <= 16'd0;
      overflow_q   <= 1'b0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= BASE;
      wr_data_q    <= NOP_WORD;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      hdr_cnt_q    <= hdr_cnt_d;
      n_q          <= n_d;
      k_q          <= k_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule
